// File: rtl/encoder_caixa_dagua.sv
// Float-switch encoder for the water tank: synchronizes and debounces the 7-bit
// thermometer sensor bus, validates the pattern and registers the committed level.
module encoder_caixa_dagua #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LOW_LEVEL       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] sensores,
  output logic [2:0] water_level,
  output logic       level_valid,
  output logic       level_changed,
  output logic       sensor_fault,
  output logic       tank_low,
  output logic       tank_full
);

  // state    | meaning
  // SETTLING | candidate pattern is being timed for stability
  // STABLE   | candidate has been committed; waiting for the bus to move
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    LOW_THR  = 3'(LOW_LEVEL);

  typedef enum logic {
    SETTLING = 1'b0,
    STABLE   = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [6:0]      s1;
  logic [6:0]      s2;
  logic [6:0]      candidate;
  logic [6:0]      candidate_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            commit;
  logic            legal;
  logic [2:0]      n_wet;
  logic [7:0]      cand_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      candidate <= '0;
      cnt       <= '0;
      state     <= SETTLING;
    end else begin
      s1        <= sensores;
      s2        <= s1;
      candidate <= candidate_next;
      cnt       <= cnt_next;
      state     <= state_next;
    end
  end

  // Any difference between the synchronized bus and the candidate restarts timing.
  always_comb begin
    state_next     = state;
    candidate_next = candidate;
    cnt_next       = cnt;
    commit         = 1'b0;
    case (state)
      STABLE: begin
        if (s2 != candidate) begin
          candidate_next = s2;
          cnt_next       = '0;
          state_next     = SETTLING;
        end
      end
      SETTLING: begin
        if (s2 != candidate) begin
          candidate_next = s2;
          cnt_next       = '0;
        end else if (cnt == CNT_LAST) begin
          commit     = 1'b1;
          state_next = STABLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = SETTLING;
    endcase
  end

  // A legal thermometer code is 2^n - 1, i.e. no set bit above a clear bit.
  always_comb begin
    cand_ext = {1'b0, candidate};
    legal    = ((cand_ext + 8'd1) & cand_ext) == 8'd0;
    n_wet    = '0;
    for (int k = 0; k < 7; k++) begin
      n_wet = n_wet + {2'b00, candidate[k]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      water_level   <= '0;
      level_valid   <= 1'b0;
      level_changed <= 1'b0;
      sensor_fault  <= 1'b0;
      tank_low      <= 1'b0;
      tank_full     <= 1'b0;
    end else begin
      level_changed <= 1'b0;
      if (commit) begin
        if (legal) begin
          water_level   <= n_wet;
          level_valid   <= 1'b1;
          sensor_fault  <= 1'b0;
          level_changed <= (n_wet != water_level) || !level_valid;
          tank_low      <= (n_wet <= LOW_THR);
          tank_full     <= (n_wet == 3'd7);
        end else begin
          // water_level keeps the last good reading for diagnostics
          level_valid  <= 1'b0;
          sensor_fault <= 1'b1;
          tank_low     <= 1'b0;
          tank_full    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_encoder_caixa_dagua.sv
// Directed self-checking bench for encoder_caixa_dagua with DEBOUNCE_CYCLES=4, LOW_LEVEL=1.
module tb_encoder_caixa_dagua;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] sensores;
  logic [2:0] water_level;
  logic       level_valid;
  logic       level_changed;
  logic       sensor_fault;
  logic       tank_low;
  logic       tank_full;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  encoder_caixa_dagua #(
    .DEBOUNCE_CYCLES(4),
    .LOW_LEVEL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sensores(sensores),
    .water_level(water_level),
    .level_valid(level_valid),
    .level_changed(level_changed),
    .sensor_fault(sensor_fault),
    .tank_low(tank_low),
    .tank_full(tank_full)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (level_changed === 1'b1) pulses++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {water_level, level_valid, level_changed, sensor_fault, tank_low, tank_full};
  endfunction

  initial begin
    // 1. power-up
    rst = 1'b1;
    sensores = 7'b0000000;
    tick(2);
    chk("reset_outputs", outs(), 8'h00);
    rst = 1'b0;
    pulses = 0;
    tick(3);
    chk("pwr_no_early_commit", {7'b0, level_valid}, 8'd0);
    tick(2);
    chk("pwr_valid", {7'b0, level_valid}, 8'd1);
    chk("pwr_level", {5'b0, water_level}, 8'd0);
    chk("pwr_tank_low", {7'b0, tank_low}, 8'd1);
    chk("pwr_tank_full", {7'b0, tank_full}, 8'd0);
    tick(10);
    chk("pwr_single_pulse", 8'(pulses), 8'd1);

    // 2. fill
    sensores = 7'b0000111;
    pulses = 0;
    tick(6);
    chk("fill3_before", {5'b0, water_level}, 8'd0);
    tick(1);
    chk("fill3_level", {5'b0, water_level}, 8'd3);
    chk("fill3_pulse", {7'b0, level_changed}, 8'd1);
    chk("fill3_tank_low", {7'b0, tank_low}, 8'd0);
    tick(1);
    chk("fill3_pulse_end", {7'b0, level_changed}, 8'd0);
    chk("fill3_pulse_count", 8'(pulses), 8'd1);
    sensores = 7'b1111111;
    tick(7);
    chk("fill7_level", {5'b0, water_level}, 8'd7);
    chk("fill7_tank_full", {7'b0, tank_full}, 8'd1);
    chk("fill7_tank_low", {7'b0, tank_low}, 8'd0);
    sensores = 7'b0000111;
    tick(10);
    chk("back3_level", {5'b0, water_level}, 8'd3);
    chk("back3_tank_full", {7'b0, tank_full}, 8'd0);

    // 3. debounce glitch
    pulses = 0;
    sensores = 7'b0001111;
    tick(3);
    sensores = 7'b0000111;
    tick(15);
    chk("glitch_level", {5'b0, water_level}, 8'd3);
    chk("glitch_no_pulse", 8'(pulses), 8'd0);
    chk("glitch_fault", {7'b0, sensor_fault}, 8'd0);
    chk("glitch_valid", {7'b0, level_valid}, 8'd1);

    // 4. illegal pattern, then recovery
    sensores = 7'b0000101;
    pulses = 0;
    tick(6);
    chk("fault_before", {7'b0, sensor_fault}, 8'd0);
    tick(1);
    chk("fault_flags", {water_level, level_valid, level_changed, sensor_fault, tank_low, tank_full},
        {3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    tick(3);
    chk("fault_no_pulse", 8'(pulses), 8'd0);
    sensores = 7'b0000011;
    tick(7);
    chk("recover_flags", {water_level, level_valid, level_changed, sensor_fault, tank_low, tank_full},
        {3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tick(5);
    chk("recover_pulse_count", 8'(pulses), 8'd1);

    // 5. reset mid-settling
    sensores = 7'b1111111;
    tick(8);
    chk("pre_rst_level", {5'b0, water_level}, 8'd7);
    sensores = 7'b0000001;
    tick(2);
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", outs(), 8'h00);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("rst_no_early_commit", {7'b0, level_valid}, 8'd0);
    tick(1);
    chk("rst_commit", {water_level, level_valid, level_changed, sensor_fault, tank_low, tank_full},
        {3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});

    // 6. bouncing bit 0, starting from a committed level 0
    sensores = 7'b0000000;
    tick(8);
    chk("bounce_base_level", {4'b0, water_level, level_valid}, {4'b0, 3'd0, 1'b1});
    pulses = 0;
    for (int p = 0; p < 20; p++) begin
      sensores = (p % 2 == 0) ? 7'b0000001 : 7'b0000000;
      tick(2);
    end
    chk("bounce_no_pulse", 8'(pulses), 8'd0);
    chk("bounce_level", {4'b0, water_level, level_valid}, {4'b0, 3'd0, 1'b1});
    sensores = 7'b0000001;
    tick(6);
    chk("bounce_before_commit", {5'b0, water_level}, 8'd0);
    tick(1);
    chk("bounce_commit_level", {5'b0, water_level}, 8'd1);
    chk("bounce_commit_pulse", {7'b0, level_changed}, 8'd1);
    tick(5);
    chk("bounce_pulse_count", 8'(pulses), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
